// File: rtl/bnn_pkg.sv
// bnn_pkg: sequencer states and frame/byte constants shared by the BNN sequencer files
package bnn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, READY, READ} state_t;
  localparam int IN_BYTES = 61;
  localparam int OUT_BYTES = 10;
  localparam logic [7:0] BUSY_BYTE = 8'hFF;
  localparam logic [7:0] PAD_BYTE = 8'h00;
endpackage

// File: rtl/bnn_ctrl_csum.sv
// bnn_ctrl_csum: modulo-256 accumulator; ports clk, rst_n (async), clr (sync), add strobe, din byte, sum value
module bnn_ctrl_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] sum
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= sum + din;
endmodule

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: SPI-session sequencer for the BNN core (SPI byte side, input-buffer write, core start/done, result read, busy/error flags; option BNN_CTRL_CHKSUM_EN)
module bnn_seq_ctrl #(
  parameter int IN_BYTES  = 61,
  parameter int OUT_BYTES = 10,
  parameter int AW_IN     = 6,
  parameter int AW_OUT    = 4
) (
  input  logic              CLOCK_50,
  input  logic              iRSTn,
  input  logic              iCLR,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic              buf_we,
  output logic [AW_IN-1:0]  buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              core_start,
  input  logic              core_done,
  output logic [AW_OUT-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic              busy,
  output logic              err_short,
  output logic              err_over
);
  import bnn_pkg::*;
  localparam logic [AW_IN:0] IN_N = IN_BYTES[AW_IN:0];
  localparam logic [AW_OUT:0] OUT_N = OUT_BYTES[AW_OUT:0];
  typedef struct packed {
    logic              cs_q;
    logic              poll;
    logic [AW_IN:0]    cnt;
    logic [AW_OUT:0]   idx;
    logic              p1;
    logic              p2;
    logic [AW_OUT:0]   k1;
    logic [AW_OUT:0]   k2;
    logic              buf_we;
    logic [AW_IN-1:0]  buf_addr;
    logic [7:0]        buf_wdata;
    logic              core_start;
    logic [AW_OUT-1:0] res_addr;
    logic              tx_load;
    logic [7:0]        tx_byte;
    logic              err_short;
    logic              err_over;
  } regs_t;
  state_t state, state_n;
  regs_t r, n;
  logic open_e, close_e, fetch, bsy;
  logic [AW_IN:0] cnt_n;
  logic [AW_OUT:0] idx_n;
  logic [7:0] csum;
  assign open_e = cs_active & ~r.cs_q;
  assign close_e = ~cs_active & r.cs_q;
`ifdef BNN_CTRL_CHKSUM_EN
  localparam logic [AW_OUT:0] OUT_END = OUT_N + 1'b1;
  bnn_ctrl_csum u_csum (
    .clk   (CLOCK_50),
    .rst_n (iRSTn),
    .clr   (!iCLR || (state == READY && open_e)),
    .add   (r.p2 && r.k2 < OUT_N),
    .din   (res_rdata),
    .sum   (csum)
  );
`else
  localparam logic [AW_OUT:0] OUT_END = OUT_N;
  assign csum = PAD_BYTE;
`endif
  always_comb begin
    cnt_n = (state == LOAD && rx_valid && r.cnt <= IN_N) ? r.cnt + 1'b1 : r.cnt;
    idx_n = (state == READ && rx_valid && r.idx <= OUT_N) ? r.idx + 1'b1 : r.idx;
    state_n = state;
    case (state)
      IDLE:    state_n = open_e ? LOAD : IDLE;
      LOAD:    state_n = !close_e ? LOAD : cnt_n >= IN_N ? RUN : IDLE;
      RUN:     state_n = core_done ? READY : RUN;
      READY:   state_n = open_e ? READ : READY;
      READ:    state_n = !close_e ? READ : idx_n >= OUT_END ? IDLE : READY;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    n = r;
    fetch = (state == READY && open_e) || (state == READ && rx_valid && !close_e);
    bsy = (state == RUN && open_e) || (r.poll && rx_valid);
    n.cs_q = cs_active;
    n.poll = (state == RUN && open_e) ? 1'b1 : close_e ? 1'b0 : r.poll;
    n.cnt = state == IDLE ? '0 : cnt_n;
    n.idx = state == READY ? '0 : idx_n;
    n.buf_we = state == LOAD && rx_valid && r.cnt < IN_N;
    n.buf_addr = n.buf_we ? r.cnt[AW_IN-1:0] : r.buf_addr;
    n.buf_wdata = n.buf_we ? rx_byte : r.buf_wdata;
    n.err_over = r.err_over || (state == LOAD && rx_valid && r.cnt >= IN_N);
    n.err_short = r.err_short || (state == LOAD && close_e && cnt_n < IN_N);
    n.core_start = state == LOAD && close_e && cnt_n >= IN_N;
    n.p1 = fetch;
    n.p2 = r.p1;
    n.k1 = fetch ? idx_n : r.k1;
    n.k2 = r.k1;
    n.res_addr = (fetch && idx_n < OUT_N) ? idx_n[AW_OUT-1:0] : r.res_addr;
    n.tx_load = bsy || r.p2;
    n.tx_byte = bsy ? BUSY_BYTE : !r.p2 ? r.tx_byte : r.k2 < OUT_N ? res_rdata : r.k2 == OUT_N ? csum : PAD_BYTE;
  end
  always_ff @(posedge CLOCK_50 or negedge iRSTn)
    if (!iRSTn) state <= IDLE;
    else state <= iCLR ? state_n : IDLE;
  always_ff @(posedge CLOCK_50 or negedge iRSTn)
    if (!iRSTn) r <= '0;
    else r <= iCLR ? n : '0;
  assign tx_byte = r.tx_byte;
  assign tx_load = r.tx_load;
  assign buf_we = r.buf_we;
  assign buf_addr = r.buf_addr;
  assign buf_wdata = r.buf_wdata;
  assign core_start = r.core_start;
  assign res_addr = r.res_addr;
  assign err_short = r.err_short;
  assign err_over = r.err_over;
  assign busy = state == RUN;
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: randomized self-checking bench for bnn_seq_ctrl against a frame/result-level model
module tb_bnn_seq_ctrl;
`ifdef BNN_CTRL_CHKSUM_EN
  localparam int FULL = 11;
`else
  localparam int FULL = 10;
`endif
  logic clk = 0, rst_n = 0, clr_n = 1, cs = 0, rx_valid = 0, core_done = 0;
  logic [7:0] rx_byte = 0, res_rdata, tx_byte, buf_wdata;
  logic tx_load, buf_we, core_start, busy, err_short, err_over;
  logic [5:0] buf_addr;
  logic [3:0] res_addr;
  logic [7:0] res_mem [16];
  logic [7:0] frame [$];
  logic [13:0] wq [$];
  logic [7:0] txq [$];
  int n_start, checks, failures;
  always #10 clk = ~clk;
  bnn_seq_ctrl dut (
    .CLOCK_50(clk), .iRSTn(rst_n), .iCLR(clr_n), .cs_active(cs), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .core_start(core_start),
    .core_done(core_done), .res_addr(res_addr), .res_rdata(res_rdata), .busy(busy),
    .err_short(err_short), .err_over(err_over)
  );
  always @(posedge clk) res_rdata <= res_mem[res_addr];
  always @(negedge clk) begin
    if (buf_we) wq.push_back({buf_addr, buf_wdata});
    if (core_start) n_start++;
    if (tx_load) txq.push_back(tx_byte);
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [7:0] exp_tx(input int j);
`ifdef BNN_CTRL_CHKSUM_EN
    logic [7:0] s = 0;
    for (int i = 0; i < 10; i++) s += res_mem[i];
    if (j == 10) return s;
`endif
    if (j < 10) return res_mem[j];
    return 8'h00;
  endfunction
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1; tick(); rx_valid = 0;
    repeat (20) tick();
  endtask
  task automatic open_s();
    cs = 1; repeat (4) tick();
  endtask
  task automatic close_s();
    cs = 0; repeat (8) tick();
  endtask
  task automatic write_session(input int len, input bit pat);
    frame.delete(); wq.delete(); n_start = 0;
    for (int i = 0; i < len; i++) frame.push_back(pat ? 8'(i) : 8'($urandom));
    open_s();
    foreach (frame[i]) send_byte(frame[i]);
    close_s();
  endtask
  task automatic run_core(input bit pat);
    for (int i = 0; i < 16; i++) res_mem[i] = pat ? 8'(i + 1) : 8'($urandom);
    repeat ($urandom_range(3, 10)) tick();
    core_done = 1; tick(); core_done = 0;
    repeat (3) tick();
  endtask
  task automatic read_session(input int m);
    txq.delete();
    open_s();
    repeat (m) send_byte(8'($urandom));
    close_s();
  endtask
  task automatic test_reset();
    rst_n = 0; repeat (3) tick();
    checks++;
    if ({tx_byte, tx_load, buf_we, buf_addr, buf_wdata, core_start, res_addr, busy, err_short, err_over} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got tx=%h ld=%b we=%b a=%0d d=%h st=%b ra=%0d busy=%b es=%b eo=%b exp all 0",
               tx_byte, tx_load, buf_we, buf_addr, buf_wdata, core_start, res_addr, busy, err_short, err_over);
    end
    rst_n = 1; repeat (2) tick();
  endtask
  task automatic test_full_write_read();
    write_session(61, 1);
    checks++; if (wq.size() != 61) begin failures++; $display("FAIL full_wr_count got=%0d exp=61", wq.size()); end
    for (int i = 0; i < wq.size() && i < 61; i++) begin
      checks++;
      if (wq[i] !== {6'(i), frame[i]}) begin failures++; $display("FAIL full_wr[%0d] got=%h exp=%h", i, wq[i], {6'(i), frame[i]}); end
    end
    checks++; if (n_start != 1) begin failures++; $display("FAIL full_start got=%0d exp=1", n_start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
    checks++; if ({err_short, err_over} !== 2'b00) begin failures++; $display("FAIL full_err got=%b exp=00", {err_short, err_over}); end
    run_core(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ready_busy got=%b exp=0", busy); end
    read_session(FULL);
    checks++; if (txq.size() != FULL + 1) begin failures++; $display("FAIL full_rd_count got=%0d exp=%0d", txq.size(), FULL + 1); end
    for (int j = 0; j < txq.size() && j <= FULL; j++) begin
      checks++;
      if (txq[j] !== exp_tx(j)) begin failures++; $display("FAIL full_rd[%0d] got=%h exp=%h", j, txq[j], exp_tx(j)); end
    end
  endtask
  task automatic test_short();
    write_session(40, 0);
    checks++; if (wq.size() != 40) begin failures++; $display("FAIL short_wr_count got=%0d exp=40", wq.size()); end
    for (int i = 0; i < wq.size() && i < 40; i++) begin
      checks++;
      if (wq[i] !== {6'(i), frame[i]}) begin failures++; $display("FAIL short_wr[%0d] got=%h exp=%h", i, wq[i], {6'(i), frame[i]}); end
    end
    checks++; if (n_start != 0) begin failures++; $display("FAIL short_start got=%0d exp=0", n_start); end
    checks++; if ({err_short, err_over, busy} !== 3'b100) begin failures++; $display("FAIL short_flags got=%b exp=100", {err_short, err_over, busy}); end
    write_session(61, 0);
    checks++; if (wq.size() != 61 || n_start != 1 || busy !== 1'b1) begin
      failures++; $display("FAIL short_retry got wr=%0d st=%0d busy=%b exp 61/1/1", wq.size(), n_start, busy);
    end
    run_core(0);
    read_session(FULL);
    checks++; if (txq.size() != FULL + 1) begin failures++; $display("FAIL rand_rd_count got=%0d exp=%0d", txq.size(), FULL + 1); end
    for (int j = 0; j < txq.size() && j <= FULL; j++) begin
      checks++;
      if (txq[j] !== exp_tx(j)) begin failures++; $display("FAIL rand_rd[%0d] got=%h exp=%h", j, txq[j], exp_tx(j)); end
    end
  endtask
  task automatic test_over();
    clr_n = 0; tick(); clr_n = 1; tick();
    checks++; if ({err_short, err_over} !== 2'b00) begin failures++; $display("FAIL clr_flags got=%b exp=00", {err_short, err_over}); end
    write_session(64, 0);
    checks++; if (wq.size() != 61) begin failures++; $display("FAIL over_wr_count got=%0d exp=61", wq.size()); end
    for (int i = 0; i < wq.size() && i < 61; i++) begin
      checks++;
      if (wq[i] !== {6'(i), frame[i]}) begin failures++; $display("FAIL over_wr[%0d] got=%h exp=%h", i, wq[i], {6'(i), frame[i]}); end
    end
    checks++; if ({err_short, err_over} !== 2'b01) begin failures++; $display("FAIL over_flags got=%b exp=01", {err_short, err_over}); end
    checks++; if (n_start != 1 || busy !== 1'b1) begin failures++; $display("FAIL over_start got st=%0d busy=%b exp 1/1", n_start, busy); end
  endtask
  task automatic test_poll_reread();
    int np;
    np = $urandom_range(1, 4);
    read_session(np);
    checks++; if (txq.size() != np + 1) begin failures++; $display("FAIL poll_count got=%0d exp=%0d", txq.size(), np + 1); end
    foreach (txq[j]) begin
      checks++; if (txq[j] !== 8'hFF) begin failures++; $display("FAIL poll[%0d] got=%h exp=ff", j, txq[j]); end
    end
    for (int i = 0; i < 16; i++) res_mem[i] = 8'($urandom);
    txq.delete();
    cs = 1; core_done = 1; tick(); core_done = 0; repeat (3) tick();
    send_byte(8'h5A); send_byte(8'hA5);
    close_s();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL poll_done_busy got=%b exp=0", busy); end
    checks++; if (txq.size() != 3 || txq[0] !== 8'hFF || txq[2] !== 8'hFF) begin
      failures++; $display("FAIL poll_done got n=%0d exp 3 bytes of ff", txq.size());
    end
    read_session(4);
    checks++; if (txq.size() != 5) begin failures++; $display("FAIL part_rd_count got=%0d exp=5", txq.size()); end
    for (int j = 0; j < txq.size() && j < 5; j++) begin
      checks++;
      if (txq[j] !== exp_tx(j)) begin failures++; $display("FAIL part_rd[%0d] got=%h exp=%h", j, txq[j], exp_tx(j)); end
    end
    read_session(FULL);
    checks++; if (txq.size() != FULL + 1) begin failures++; $display("FAIL reread_count got=%0d exp=%0d", txq.size(), FULL + 1); end
    for (int j = 0; j < txq.size() && j <= FULL; j++) begin
      checks++;
      if (txq[j] !== exp_tx(j)) begin failures++; $display("FAIL reread[%0d] got=%h exp=%h", j, txq[j], exp_tx(j)); end
    end
  endtask
  task automatic test_reset_mid();
    open_s();
    for (int i = 0; i < 30; i++) send_byte(8'($urandom));
    rst_n = 0; cs = 0; repeat (3) tick();
    checks++;
    if ({tx_byte, tx_load, buf_we, buf_addr, buf_wdata, core_start, res_addr, busy, err_short, err_over} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got tx=%h we=%b a=%0d d=%h ra=%0d busy=%b es=%b eo=%b exp all 0",
               tx_byte, buf_we, buf_addr, buf_wdata, res_addr, busy, err_short, err_over);
    end
    rst_n = 1; repeat (2) tick();
    test_full_write_read();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) res_mem[i] = '0;
    test_reset();
    test_full_write_read();
    test_short();
    test_over();
    test_poll_reread();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
